sb_io_halfduplex_ctrl: RTL and testbench

//  Sequences one half-duplex serial transaction over a registered bidirectional pin (SB_IO inout wrapper).

---
 rtl/sb_io_halfduplex_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sb_io_halfduplex_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_io_halfduplex_ctrl.sv
// Half-duplex write/turnaround/read sequencer for a registered SB_IO bidirectional pad.
// Optional echo checking of driven bits is enabled by defining SB_IO_HALFDUPLEX_ECHO_EN.
module sb_io_halfduplex_ctrl #(
   parameter int unsigned WR_W   = 8,
   parameter int unsigned RD_W   = 8,
   parameter int unsigned TURN   = 2,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [WR_W-1:0]            wr_data,
   input  logic [$clog2(WR_W+1)-1:0]  wr_bits,
   input  logic [$clog2(RD_W+1)-1:0]  rd_bits,
   output logic                       busy,
   output logic                       done,
   output logic [RD_W-1:0]            rd_data,
   output logic                       err,
   output logic                       io_oe,
   output logic                       io_out,
   input  logic                       io_in
);

   localparam int unsigned WBW  = $clog2(WR_W + 1);
   localparam int unsigned RBW  = $clog2(RD_W + 1);
   localparam int unsigned MAXW = (WR_W > RD_W) ? WR_W : RD_W;
   localparam int unsigned CW   = $clog2(MAXW + RD_LAT + TURN + 1);

   typedef enum logic [1:0] {StIdle, StWrite, StTurn, StRead} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WR_W-1:0] wr_sh_q, wr_sh_d;
   logic [WBW-1:0]  wr_n_q, wr_n_d;
   logic [RBW-1:0]  rd_n_q, rd_n_d;
   logic [RD_W-1:0] rd_data_q, rd_data_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            oe_q, oe_d;
   logic            out_q, out_d;

   logic [WBW-1:0]  wr_n_in;
   logic [RBW-1:0]  rd_n_in;
   logic [WR_W-1:0] wr_aligned;

   assign wr_n_in    = (wr_bits > WBW'(WR_W)) ? WBW'(WR_W) : wr_bits;
   assign rd_n_in    = (rd_bits > RBW'(RD_W)) ? RBW'(RD_W) : rd_bits;
   // Move the first bit to be sent into the MSB of the shift register.
   assign wr_aligned = wr_data << (WBW'(WR_W) - wr_n_in);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_sh_d   = wr_sh_q;
      wr_n_d    = wr_n_q;
      rd_n_d    = rd_n_q;
      rd_data_d = rd_data_q;
      done_d    = 1'b0;
      oe_d      = 1'b0;
      out_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               wr_n_d = wr_n_in;
               rd_n_d = rd_n_in;
               cnt_d  = '0;
               if (rd_n_in != '0) rd_data_d = '0;
               if (wr_n_in != '0) begin
                  state_d = StWrite;
                  oe_d    = 1'b1;
                  out_d   = wr_aligned[WR_W-1];
                  wr_sh_d = wr_aligned << 1;
               end else if (rd_n_in != '0) begin
                  state_d = StTurn;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StWrite: begin
            if ((cnt_q + CW'(1)) == CW'(wr_n_q)) begin
               cnt_d = '0;
               if (rd_n_q != '0) begin
                  state_d = StTurn;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d   = cnt_q + CW'(1);
               oe_d    = 1'b1;
               out_d   = wr_sh_q[WR_W-1];
               wr_sh_d = wr_sh_q << 1;
            end
         end
         StTurn: begin
            if ((cnt_q + CW'(1)) == CW'(TURN)) begin
               state_d = StRead;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StRead: begin
            // First RD_LAT read cycles still carry the pad round trip of the release.
            if (cnt_q >= CW'(RD_LAT)) rd_data_d = (rd_data_q << 1) | RD_W'(io_in);
            if ((cnt_q + CW'(1)) == (CW'(RD_LAT) + CW'(rd_n_q))) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy_d = (state_d != StIdle);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         wr_sh_q   <= '0;
         wr_n_q    <= '0;
         rd_n_q    <= '0;
         rd_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         oe_q      <= 1'b0;
         out_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_sh_q   <= wr_sh_d;
         wr_n_q    <= wr_n_d;
         rd_n_q    <= rd_n_d;
         rd_data_q <= rd_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         oe_q      <= oe_d;
         out_q     <= out_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_data = rd_data_q;
   assign io_oe   = oe_q;
   assign io_out  = out_q;

`ifdef SB_IO_HALFDUPLEX_ECHO_EN
   // Each driven bit travels RD_LAT stages and meets its own echo on io_in.
   logic [RD_LAT-1:0] exp_pipe_q, vld_pipe_q;
   logic              err_q;
   logic              mismatch;

   assign mismatch = vld_pipe_q[RD_LAT-1] && (exp_pipe_q[RD_LAT-1] != io_in);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         exp_pipe_q <= '0;
         vld_pipe_q <= '0;
         err_q      <= 1'b0;
      end else begin
         exp_pipe_q <= (exp_pipe_q << 1) | RD_LAT'(out_q);
         vld_pipe_q <= (vld_pipe_q << 1) | RD_LAT'(oe_q);
         if ((state_q == StIdle) && start) err_q <= 1'b0;
         else if (mismatch)               err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sb_io_halfduplex_ctrl.sv
// Bench for sb_io_halfduplex_ctrl: registered pad model with a remote responder,
// transaction table plus hand-written handshake/reset/echo sequences, done-time scoreboard.
module tb_sb_io_halfduplex_ctrl;

   localparam int TURN   = 2;
   localparam int RD_LAT = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] wr_data = '0;
   logic [3:0] wr_bits = '0;
   logic [3:0] rd_bits = '0;
   logic       busy, done, err, io_oe, io_out;
   logic [7:0] rd_data;
   logic       io_in = 1'b0;

   sb_io_halfduplex_ctrl #(
      .WR_W   (8),
      .RD_W   (8),
      .TURN   (TURN),
      .RD_LAT (RD_LAT)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .wr_data (wr_data),
      .wr_bits (wr_bits),
      .rd_bits (rd_bits),
      .busy    (busy),
      .done    (done),
      .rd_data (rd_data),
      .err     (err),
      .io_oe   (io_oe),
      .io_out  (io_out),
      .io_in   (io_in)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] wd;
      int         wb;
      int         rb;
      logic [7:0] pat;
   } vec_t;

   typedef struct {
      int         done_cyc;
      logic [7:0] rd;
      int         wn;
      int         wseq;
      int         oe0;
      logic       err;
   } exp_t;

   exp_t       sbq[$];
   exp_t       e;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_rd = '0;

   // Pad: output register then input register; remote device answers after turnaround.
   logic       oe_d1 = 1'b0, out_d1 = 1'b0, pin;
   int         r_acc = -1000, r_wn = 0, r_rn = 0, force_cyc = -1, pin_j;
   logic [7:0] r_pat = '0;

   always_comb begin
      pin_j = cyc - (r_acc + 2 + r_wn + TURN);
      if (oe_d1)                        pin = out_d1 && (cyc != force_cyc);
      else if (pin_j >= 0 && pin_j < r_rn) pin = r_pat[r_rn-1-pin_j];
      else                              pin = 1'b0;
   end

   always @(posedge clock) begin
      oe_d1  <= io_oe;
      out_d1 <= io_out;
      io_in  <= pin;
      cyc    <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Called in the accept cycle: records the expected outcome and arms the remote device.
   task automatic push_exp(input logic [7:0] wd, input int wb, input int rb,
                           input logic [7:0] pat, input logic e_err);
      exp_t x;
      int   wn, rn;
      wn = (wb > 8) ? 8 : wb;
      rn = (rb > 8) ? 8 : rb;
      if (rn > 0) last_rd = pat & 8'((1 << rn) - 1);
      x.done_cyc = cyc + 1 + wn + ((rn > 0) ? (TURN + RD_LAT + rn) : 0);
      x.rd       = last_rd;
      x.wn       = wn;
      x.wseq     = int'(wd) & ((1 << wn) - 1);
      x.oe0      = (rn > 0) ? (TURN + RD_LAT + rn) : 0;
      x.err      = e_err;
      r_acc = cyc;
      r_wn  = wn;
      r_rn  = rn;
      r_pat = pat;
      sbq.push_back(x);
   endtask

   task automatic do_txn(input logic [7:0] wd, input int wb, input int rb,
                         input logic [7:0] pat, input logic e_err);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (busy) chk("start_wait_timeout", busy, 0);
      wr_data = wd;
      wr_bits = 4'(wb);
      rd_bits = 4'(rb);
      start   = 1'b1;
      push_exp(wd, wb, rb, pat, e_err);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sbq.size() != 0 || busy) && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk("drain_pending", sbq.size(), 0);
   endtask

   // Monitor: collects pin activity per transaction and scores it at done.
   int wcnt = 0, wseq = 0, oe0 = 0, outbad = 0;

   always @(negedge clock) begin
      if (reset) begin
         wcnt = 0; wseq = 0; oe0 = 0; outbad = 0;
      end else begin
         if (io_oe) begin
            wcnt++;
            wseq = (wseq << 1) | int'(io_out);
         end else if (busy) begin
            oe0++;
            if (io_out) outbad++;
         end
         if (done) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("done_cycle", cyc, e.done_cyc);
               chk("rd_data", int'(rd_data), int'(e.rd));
               chk("write_bit_count", wcnt, e.wn);
               chk("write_bit_values", wseq, e.wseq);
               chk("released_cycles", oe0, e.oe0);
               chk("io_out_low_when_released", outbad, 0);
               chk("busy_at_done", int'(busy), 0);
               chk("err_at_done", int'(err), int'(e.err));
            end
            wcnt = 0; wseq = 0; oe0 = 0; outbad = 0;
         end
      end
   end

   vec_t vecs[7];

   initial begin
      vecs[0] = '{8'hA5, 8, 8, 8'h3C};   // full transfer
      vecs[1] = '{8'h00, 0, 0, 8'h00};   // zero lengths
      vecs[2] = '{8'hFF, 3, 12, 8'h96};  // read count clamps to 8
      vecs[3] = '{8'h5A, 4, 0, 8'h00};   // write only, rd_data held
      vecs[4] = '{8'h00, 0, 5, 8'h16};   // read only, upper bits zero
      vecs[5] = '{8'hC3, 15, 3, 8'h05};  // write count clamps to 8
      vecs[6] = '{8'h81, 1, 1, 8'h01};   // single bits

      repeat (3) @(negedge clock);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_io_oe", int'(io_oe), 0);
      chk("reset_io_out", int'(io_out), 0);
      chk("reset_rd_data", int'(rd_data), 0);
      chk("reset_err", int'(err), 0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 7; i++) begin
         do_txn(vecs[i].wd, vecs[i].wb, vecs[i].rb, vecs[i].pat, 1'b0);
      end
      wait_idle();

      // Start held high: second accept lands on the done cycle (accept+8).
      wr_data = 8'h6B; wr_bits = 4'd2; rd_bits = 4'd1; start = 1'b1;
      push_exp(8'h6B, 2, 1, 8'h01, 1'b0);
      repeat (8) @(negedge clock);
      chk("held_start_done_cycle", int'(done), 1);
      push_exp(8'h6B, 2, 1, 8'h00, 1'b0);
      @(negedge clock);
      start = 1'b0;
      chk("held_start_busy_again", int'(busy), 1);
      // Pulses while busy must be dropped.
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         wr_data = 8'hFF; wr_bits = 4'd8; rd_bits = 4'd8; start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
      wait_idle();
      repeat (4) @(negedge clock);

      // Reset during write cycle index 3.
      wr_data = 8'hA5; wr_bits = 4'd8; rd_bits = 4'd4; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("pre_reset_io_oe", int'(io_oe), 1);
      #1;
      reset = 1'b1;
      sbq.delete();
      last_rd = '0;
      r_rn = 0;
      #1;
      chk("async_reset_io_oe", int'(io_oe), 0);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_done", int'(done), 0);
      @(negedge clock);
      chk("reset_clears_rd_data", int'(rd_data), 0);
      @(posedge clock);
      #2;
      reset = 1'b0;
      repeat (12) @(negedge clock);
      chk("idle_after_reset", int'(busy), 0);
      do_txn(8'h3C, 6, 3, 8'h05, 1'b0);
      wait_idle();

`ifdef SB_IO_HALFDUPLEX_ECHO_EN
      // Third driven bit (write cycle index 2) is pulled low on the pin.
      force_cyc = cyc + 4;
      do_txn(8'hFF, 8, 0, 8'h00, 1'b1);
      repeat (3) @(negedge clock);
      chk("echo_err_before_fault", int'(err), 0);
      repeat (2) @(negedge clock);
      chk("echo_err_set", int'(err), 1);
      wait_idle();
      force_cyc = -1;
      do_txn(8'h00, 2, 0, 8'h00, 1'b0);
      chk("echo_err_cleared_on_accept", int'(err), 0);
      wait_idle();
`endif

      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=0", cyc);
      $fatal(1);
   end

endmodule
